// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative MIPS multiply/divide unit with architectural HI/LO.
//            One shift-add / restoring shift-subtract step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] C_OP_MTHI = 3'b100;
    localparam logic [2:0] C_OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;        // product high half or partial remainder
    logic [WIDTH-1:0] work_q, work_d;      // multiplier / dividend shifting into quotient
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             w_signed_op;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

    assign w_signed_op = ~op[0];
    assign w_mag_a     = (w_signed_op && a[WIDTH-1]) ? ('0 - a) : a;
    assign w_mag_b     = (w_signed_op && b[WIDTH-1]) ? ('0 - b) : b;

    assign w_mul_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);

    // The true difference is below 2^WIDTH whenever it is taken, so a
    // WIDTH-bit modular subtract is exact; the compare uses the full shift.
    assign w_div_shift = {acc_q, work_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - opnd_q;

    assign w_prod      = {acc_q, work_q};
    assign w_prod_fix  = neg_res_q ? ('0 - w_prod) : w_prod;
    assign w_quo_fix   = div_zero_q ? '1 : (neg_res_q ? ('0 - work_q) : work_q);
    assign w_rem_fix   = neg_rem_q ? ('0 - acc_q) : acc_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        work_d     = work_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        opnd_d     = op[1] ? w_mag_b : w_mag_a;
                        work_d     = op[1] ? w_mag_a : w_mag_b;
                        acc_d      = '0;
                        count_d    = '0;
                        is_div_d   = op[1];
                        neg_res_d  = w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d  = w_signed_op & op[1] & a[WIDTH-1];
                        div_zero_d = op[1] & (b == '0);
                        busy_d     = 1'b1;
                        state_d    = ST_CALC;
                    end else if (op == C_OP_MTHI) begin
                        hi_d = a;
                    end else if (op == C_OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    acc_d  = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], w_div_ge};
                end else begin
                    acc_d  = w_mul_sum[WIDTH:1];
                    work_d = {w_mul_sum[0], work_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            work_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
